board_ctrl: RTL
===============

Name: board_ctrl

Overview:
Game-board controller for the tic-tac-toe VGA pipeline. It converts mouse clicks into square occupancy and owner flags, alternates turns, and detects win or draw. It drives the per-square enable and colour inputs of the nine square-drawing stages, so it decides which squares are painted and in which colour.

Parameters:
COLOR_X, 12'hF00, square_color for squares owned by player X
COLOR_O, 12'h00F, square_color for squares owned by player O
COL0_MAX, 338, last x pixel of column 0
COL1_MAX, 684, last x pixel of column 1
ROW0_MAX, 252, last y pixel of row 0
ROW1_MAX, 514, last y pixel of row 1
ROW2_MAX, 767, last y pixel of row 2; clicks with y above this are ignored
RESTART_CYCLES, 65_000_000, game-over hold time before auto clear (used only with the optional feature)

Ports:
pclk  input  1  pixel clock
rst  input  1  synchronous, active-high reset
start_en  input  1  game screen active
choice_en  input  1  player-choice menu active; clicks are ignored while it is high
new_game  input  1  one-cycle pulse; clears the board
click  input  1  one-cycle left-click pulse
click_x  input  12  mouse x at click
click_y  input  12  mouse y at click
square_en  output  9  bit k-1 high when square k is occupied (feeds squareN)
square_owner  output  9  bit k-1: 0 = X, 1 = O; valid only where square_en is set
square_color  output  108  9 x 12-bit colours; slice k-1 is COLOR_X or COLOR_O per owner
turn  output  1  0 = X to move, 1 = O to move
winner  output  2  00 none, 01 X, 10 O, 11 draw
game_over  output  1  high in DONE state

Behaviour:
- Reset: square_en=0, square_owner=0, turn=0, winner=00, game_over=0, state=IDLE, restart counter=0. All outputs are registered.
- Square mapping:
  - col = 0 if x<=COL0_MAX, 1 if x<=COL1_MAX, else 2.
  - row = 0 if y<=ROW0_MAX, 1 if y<=ROW1_MAX, 2 if y<=ROW2_MAX, else invalid.
  - square number = row*3+col+1, so square7 is row 2, col 0.
- Click acceptance: a click is valid only when click=1, start_en=1, choice_en=0, state=PLAY, row is valid, and the square is unoccupied. All other clicks are dropped silently.
- FSM states: IDLE, PLAY, CHECK, DONE.
  - IDLE -> PLAY when start_en && !choice_en.
  - PLAY -> CHECK on a valid click at edge N. At edge N the square's square_en bit is set, its owner bit is set to turn, and turn toggles.
  - CHECK (one cycle) evaluates the 8 lines (3 rows, 3 columns, 2 diagonals) on the registered board.
    - A line with all three squares occupied and the same owner sets winner to 01 or 10 at edge N+1 and goes to DONE.
    - Otherwise, if all 9 squares are occupied, winner=11 and go to DONE.
    - Otherwise return to PLAY.
  - DONE: game_over=1; board frozen; clicks ignored.
- Latency: click to square_en update is 1 cycle; click to winner/game_over is 2 cycles.
- Clicks arriving in CHECK are dropped, not queued.
- new_game has priority over a click in the same cycle and acts in any state except IDLE. It clears board, turn, winner and game_over; the next state is PLAY if start_en && !choice_en, else IDLE.
- start_en falling in any state: go to IDLE next cycle; the board is kept.
- square_color is combinational from square_owner only (X -> COLOR_X, O -> COLOR_O); it does not depend on square_en.
- rst mid-game: everything returns to reset values at the next edge, overriding all other inputs.

Optional Feature:
- Macro: BOARD_CTRL_AUTO_RESTART_EN.
- Defined:
  - In DONE a 27-bit counter counts pclk cycles from 0.
  - When it reaches RESTART_CYCLES-1 the board clears as for new_game and the counter resets.
  - new_game or rst also clears the counter.
- Undefined: the counter is absent, and DONE persists until new_game, rst or start_en low.

Test Plan:
- Reset then start_en=1, choice_en=0, click at (100,600) -> after 1 cycle square_en=9'b001000000, square_owner=0, turn=1; winner=00.
- Click at (100,600) again on the occupied square7 -> no change to square_en, square_owner or turn.
- X plays squares 1,2,3 with O playing 4,5 in between -> 2 cycles after the 5th click winner=01, game_over=1; a further click at (800,100) is ignored.
- Full board with no line (X:1,3,4,8,9 / O:2,5,6,7) -> winner=11 after the 9th move.
- Click pulse with choice_en=1, then a click with y=800 -> both ignored; new_game and click in the same cycle -> board cleared, click dropped.
- With BOARD_CTRL_AUTO_RESTART_EN and RESTART_CYCLES=10, win reached -> board clears exactly 10 cycles after game_over rises; without the macro, game_over stays high for 100 cycles.

Source files
------------

// File: rtl/board_ctrl.sv
// Tic-tac-toe board controller: maps clicks to squares, alternates turns, detects win/draw.
// Optional auto-clear after game over is enabled with `define BOARD_CTRL_AUTO_RESTART_EN.
module board_ctrl #(
    parameter logic [11:0] COLOR_X        = 12'hF00,
    parameter logic [11:0] COLOR_O        = 12'h00F,
    parameter int          COL0_MAX       = 338,
    parameter int          COL1_MAX       = 684,
    parameter int          ROW0_MAX       = 252,
    parameter int          ROW1_MAX       = 514,
    parameter int          ROW2_MAX       = 767,
    parameter int          RESTART_CYCLES = 65_000_000
) (
    input  logic           pclk,
    input  logic           rst,
    input  logic           start_en,
    input  logic           choice_en,
    input  logic           new_game,
    input  logic           click,
    input  logic [11:0]    click_x,
    input  logic [11:0]    click_y,
    output logic [8:0]     square_en,
    output logic [8:0]     square_owner,
    output logic [107:0]   square_color,
    output logic           turn,
    output logic [1:0]     winner,
    output logic           game_over
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PLAY  = 2'd1,
        S_CHECK = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [8:0]  r_en, w_en_nxt;
    logic [8:0]  r_own, w_own_nxt;
    logic        r_turn, w_turn_nxt;
    logic [1:0]  r_winner, w_winner_nxt;
    logic        r_over, w_over_nxt;
    logic [1:0]  w_col, w_row;
    logic        w_row_ok;
    logic [3:0]  w_idx;
    logic        w_click_ok;
    logic [1:0]  w_result;
`ifdef BOARD_CTRL_AUTO_RESTART_EN
    logic [26:0] r_cnt, w_cnt_nxt;
`else
    logic [26:0] w_unused_restart;
    assign w_unused_restart = 27'(RESTART_CYCLES);
`endif

    // 01 = X owns the line, 10 = O owns it, 00 = line not complete or mixed
    function automatic logic [1:0] line_chk(input logic [2:0] e, input logic [2:0] o);
        logic [1:0] res;
        if (&e) begin
            if (o == 3'b000)      res = 2'b01;
            else if (o == 3'b111) res = 2'b10;
            else                  res = 2'b00;
        end else begin
            res = 2'b00;
        end
        return res;
    endfunction

    function automatic logic [1:0] board_result(input logic [8:0] e, input logic [8:0] o);
        logic [1:0] l [8];
        logic [1:0] res;
        l[0] = line_chk({e[0], e[1], e[2]}, {o[0], o[1], o[2]});
        l[1] = line_chk({e[3], e[4], e[5]}, {o[3], o[4], o[5]});
        l[2] = line_chk({e[6], e[7], e[8]}, {o[6], o[7], o[8]});
        l[3] = line_chk({e[0], e[3], e[6]}, {o[0], o[3], o[6]});
        l[4] = line_chk({e[1], e[4], e[7]}, {o[1], o[4], o[7]});
        l[5] = line_chk({e[2], e[5], e[8]}, {o[2], o[5], o[8]});
        l[6] = line_chk({e[0], e[4], e[8]}, {o[0], o[4], o[8]});
        l[7] = line_chk({e[2], e[4], e[6]}, {o[2], o[4], o[6]});
        res = 2'b00;
        for (int i = 7; i >= 0; i--) begin
            if (l[i] != 2'b00) res = l[i];
            else               res = res;
        end
        if (res == 2'b00) res = (&e) ? 2'b11 : 2'b00;
        else              res = res;
        return res;
    endfunction

    // Pixel coordinate to square index (row*3+col, zero-based)
    always_comb begin
        w_col    = 2'd2;
        w_row    = 2'd0;
        w_row_ok = 1'b0;
        if (click_x <= 12'(COL0_MAX))      w_col = 2'd0;
        else if (click_x <= 12'(COL1_MAX)) w_col = 2'd1;
        else                               w_col = 2'd2;
        if (click_y <= 12'(ROW0_MAX))      begin w_row = 2'd0; w_row_ok = 1'b1; end
        else if (click_y <= 12'(ROW1_MAX)) begin w_row = 2'd1; w_row_ok = 1'b1; end
        else if (click_y <= 12'(ROW2_MAX)) begin w_row = 2'd2; w_row_ok = 1'b1; end
        else                               begin w_row = 2'd0; w_row_ok = 1'b0; end
        w_idx = (4'(w_row) * 4'd3) + 4'(w_col);
    end

    assign w_click_ok = click && start_en && !choice_en && (r_state == S_PLAY)
                        && w_row_ok && !r_en[w_idx];
    assign w_result   = board_result(r_en, r_own);

    // Next-state and next-board logic; new_game outranks start_en falling and clicks
    always_comb begin
        w_state_nxt  = r_state;
        w_en_nxt     = r_en;
        w_own_nxt    = r_own;
        w_turn_nxt   = r_turn;
        w_winner_nxt = r_winner;
        w_over_nxt   = r_over;
`ifdef BOARD_CTRL_AUTO_RESTART_EN
        w_cnt_nxt    = 27'd0;
`endif
        if (new_game && (r_state != S_IDLE)) begin
            w_en_nxt     = 9'd0;
            w_own_nxt    = 9'd0;
            w_turn_nxt   = 1'b0;
            w_winner_nxt = 2'b00;
            w_over_nxt   = 1'b0;
            w_state_nxt  = (start_en && !choice_en) ? S_PLAY : S_IDLE;
        end else if (!start_en) begin
            w_state_nxt = S_IDLE;
            w_over_nxt  = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!choice_en) w_state_nxt = S_PLAY;
                    else            w_state_nxt = S_IDLE;
                end
                S_PLAY: begin
                    if (w_click_ok) begin
                        w_en_nxt[w_idx]  = 1'b1;
                        w_own_nxt[w_idx] = r_turn;
                        w_turn_nxt       = ~r_turn;
                        w_state_nxt      = S_CHECK;
                    end else begin
                        w_state_nxt = S_PLAY;
                    end
                end
                S_CHECK: begin
                    if (w_result != 2'b00) begin
                        w_winner_nxt = w_result;
                        w_over_nxt   = 1'b1;
                        w_state_nxt  = S_DONE;
                    end else begin
                        w_state_nxt = S_PLAY;
                    end
                end
                S_DONE: begin
`ifdef BOARD_CTRL_AUTO_RESTART_EN
                    if (r_cnt == 27'(RESTART_CYCLES - 1)) begin
                        w_en_nxt     = 9'd0;
                        w_own_nxt    = 9'd0;
                        w_turn_nxt   = 1'b0;
                        w_winner_nxt = 2'b00;
                        w_over_nxt   = 1'b0;
                        w_state_nxt  = choice_en ? S_IDLE : S_PLAY;
                    end else begin
                        w_cnt_nxt   = r_cnt + 27'd1;
                        w_state_nxt = S_DONE;
                    end
`else
                    w_state_nxt = S_DONE;
`endif
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // State and board registers with synchronous reset
    always_ff @(posedge pclk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_en     <= 9'd0;
            r_own    <= 9'd0;
            r_turn   <= 1'b0;
            r_winner <= 2'b00;
            r_over   <= 1'b0;
`ifdef BOARD_CTRL_AUTO_RESTART_EN
            r_cnt    <= 27'd0;
`endif
        end else begin
            r_state  <= w_state_nxt;
            r_en     <= w_en_nxt;
            r_own    <= w_own_nxt;
            r_turn   <= w_turn_nxt;
            r_winner <= w_winner_nxt;
            r_over   <= w_over_nxt;
`ifdef BOARD_CTRL_AUTO_RESTART_EN
            r_cnt    <= w_cnt_nxt;
`endif
        end
    end

    assign square_en    = r_en;
    assign square_owner = r_own;
    assign turn         = r_turn;
    assign winner       = r_winner;
    assign game_over    = r_over;

    for (genvar k = 0; k < 9; k++) begin : g_color
        assign square_color[k*12 +: 12] = r_own[k] ? COLOR_O : COLOR_X;
    end

endmodule
